// File: rtl/rom_fetch_pkg.sv
// Shared definitions for the ROM instruction-fetch sequencer: FSM state encoding and the NOP word.
package rom_fetch_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } fetch_state_e;

    // RISC-V addi x0,x0,0; presented on instr_data whenever the buffer is empty
    localparam logic [31:0] NopWord = 32'h0000_0013;

endpackage

// File: rtl/rom_fetch_ctrl_fetch_fifo.sv
// Prefetch buffer: synchronous FIFO with push, pop and flush; flush wins over push, pop may share
// the flush cycle.
module fetch_fifo #(
    parameter int unsigned Depth = 2,
    parameter int unsigned Width = 38
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [Width-1:0]           data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [Width-1:0]           data_o,
    output logic [$clog2(Depth):0]     count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PtrBits = $clog2(Depth);
    localparam int unsigned CntBits = PtrBits + 1;

    logic [Width-1:0]   mem_q [Depth];
    logic [PtrBits-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntBits-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (push_i && !pop_i) begin
            count_d = count_q + CntBits'(1);
        end else if (pop_i && !push_i) begin
            count_d = count_q - CntBits'(1);
        end
    end

    // Depth is a power of two, so pointers wrap naturally
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + PtrBits'(1);
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + PtrBits'(1);
            end
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CntBits'(Depth));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/rom_fetch_ctrl.sv
// Instruction-fetch sequencer for a combinational 32-bit ROM with a PC-tagged prefetch buffer.
// Optional ROM debug read port enabled by defining ROM_DBG_PORT_EN.
module rom_fetch_ctrl
    import rom_fetch_pkg::*;
#(
    parameter int unsigned          ADDR_BITS  = 4,
    parameter logic [ADDR_BITS+1:0] RESET_PC   = '0,
    parameter int unsigned          FIFO_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fetch_en,
    output logic [ADDR_BITS-1:0]   rom_addr,
    input  logic [31:0]            rom_data,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [31:0]            instr_data,
    output logic [ADDR_BITS+1:0]   instr_pc,
    input  logic                   redirect_valid,
`ifdef ROM_DBG_PORT_EN
    input  logic [ADDR_BITS+1:0]   redirect_pc,
    input  logic                   dbg_req,
    input  logic [ADDR_BITS-1:0]   dbg_addr,
    output logic                   dbg_rvalid,
    output logic [31:0]            dbg_rdata
`else
    input  logic [ADDR_BITS+1:0]   redirect_pc
`endif
);

    localparam int unsigned        PcBits      = ADDR_BITS + 2;
    localparam int unsigned        CntBits     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [PcBits-1:0]  PcAlignMask = ~PcBits'(3);

    fetch_state_e        state_q, state_d;
    logic [PcBits-1:0]   fetch_pc_q, fetch_pc_d;
    logic                fifo_full, fifo_empty;
    logic [CntBits-1:0]  fifo_count;
    logic [31+PcBits:0]  head_entry;
    logic                pop, flush, fetch, dbg_grant;

`ifdef ROM_DBG_PORT_EN
    assign dbg_grant = dbg_req;
    assign rom_addr  = dbg_req ? dbg_addr : fetch_pc_q[PcBits-1:2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_rvalid <= 1'b0;
            dbg_rdata  <= '0;
        end else begin
            dbg_rvalid <= dbg_req;
            if (dbg_req) begin
                dbg_rdata <= rom_data;
            end
        end
    end
`else
    assign dbg_grant = 1'b0;
    assign rom_addr  = fetch_pc_q[PcBits-1:2];
`endif

    assign pop   = ~fifo_empty & instr_ready;
    assign flush = redirect_valid & (state_q == StRun);
    // fetch_en low stops new captures immediately, even on the cycle the FSM leaves StRun
    assign fetch = (state_q == StRun) & fetch_en & (~fifo_full | pop) & ~redirect_valid
                   & ~dbg_grant;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        case (state_q)
            StIdle:  if (fetch_en) state_d = StRun;
            StRun:   if (!fetch_en) state_d = StDrain;
            StDrain: begin
                if (fetch_en) begin
                    state_d = StRun;
                end else if (fifo_count == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc & PcAlignMask;
        end else if (fetch) begin
            fetch_pc_d = fetch_pc_q + PcBits'(4);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            fetch_pc_q <= RESET_PC & PcAlignMask;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .Depth (FIFO_DEPTH),
        .Width (32 + PcBits)
    ) u_fetch_fifo (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .push_i  (fetch),
        .data_i  ({rom_data, fetch_pc_q}),
        .pop_i   (pop),
        .flush_i (flush),
        .data_o  (head_entry),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign instr_valid = ~fifo_empty;
    assign instr_pc    = head_entry[PcBits-1:0];
    assign instr_data  = fifo_empty ? NopWord : head_entry[31+PcBits:PcBits];

endmodule
